// File: rtl/card_deck_module_if.sv
// Card-fetch interface between the blackjack game FSM (master) and the
// card deck (slave). The game FSM drives the deck index and shuffle request;
// the deck returns the registered card value and its ready flag.
interface card_deck_module_if;
    logic [5:0] addrCard;
    logic       shuffle;
    logic [3:0] card;
    logic       ready;

    modport master (
        output addrCard,
        output shuffle,
        input  card,
        input  ready
    );

    modport slave (
        input  addrCard,
        input  shuffle,
        output card,
        output ready
    );
endinterface

// File: rtl/card_deck_module.sv
// card_deck_module: 52-card blackjack value deck with a registered,
// fully pipelined read port and an optional in-place Fisher-Yates shuffle
// driven by a free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
//
// Build option: define CARD_DECK_SHUFFLE_EN to compile in the LFSR and the
// PICK/SWAP states. Without it the deck stays in ordered order, shuffle is
// ignored and LFSR_SEED is unused.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | write deck[idx] with its ordered value, one entry per cycle
// IDLE  | deck stable, ready=1, card reads served
// PICK  | draw candidate j from the LFSR until j <= idx
// SWAP  | exchange deck[idx] and deck[j], step idx down
module card_deck_module #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                clk,
    input logic                reset,
    card_deck_module_if.slave  bus
);

    typedef enum logic [1:0] {INIT, IDLE, PICK, SWAP} state_t;

    state_t     state;
    state_t     state_next;
    logic       init_go;
    logic [5:0] idx;
    logic [3:0] rank;
    logic [3:0] deck [0:51];
    logic       ready_int;
    logic [3:0] card_q;

`ifdef CARD_DECK_SHUFFLE_EN
    logic [15:0] lfsr;
    logic [5:0]  jdx;
    logic [5:0]  mask;
    logic [5:0]  cand;
    logic        cand_ok;

    // Free-running LFSR; advancing in every state lets request timing add entropy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Mask is the smallest all-ones value covering idx, so rejection keeps j uniform.
    always_comb begin
        mask = 6'd63;
        if (idx < 6'd2)       mask = 6'd1;
        else if (idx < 6'd4)  mask = 6'd3;
        else if (idx < 6'd8)  mask = 6'd7;
        else if (idx < 6'd16) mask = 6'd15;
        else if (idx < 6'd32) mask = 6'd31;
        cand    = lfsr[5:0] & mask;
        cand_ok = (cand <= idx);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.shuffle, LFSR_SEED};
`endif

    // First edge after reset release only arms INIT so the release edge never
    // coincides with a deck write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_go <= 1'b0;
        end else begin
            init_go <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            INIT: begin
                if (init_go && idx == 6'd51) state_next = IDLE;
            end
            IDLE: begin
`ifdef CARD_DECK_SHUFFLE_EN
                if (bus.shuffle) state_next = PICK;
`endif
            end
`ifdef CARD_DECK_SHUFFLE_EN
            PICK: begin
                if (cand_ok) state_next = SWAP;
            end
            SWAP: begin
                if (idx == 6'd1) state_next = IDLE;
                else             state_next = PICK;
            end
`endif
            default: state_next = INIT;
        endcase
    end

    // Output logic: the deck is only readable while idle.
    always_comb begin
        ready_int = (state == IDLE);
    end

    // Deck index, rank tracker for INIT and latched swap partner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx  <= 6'd0;
            rank <= 4'd1;
`ifdef CARD_DECK_SHUFFLE_EN
            jdx  <= 6'd0;
`endif
        end else begin
            case (state)
                INIT: begin
                    if (init_go && idx != 6'd51) begin
                        idx  <= idx + 6'd1;
                        rank <= (rank == 4'd13) ? 4'd1 : rank + 4'd1;
                    end
                end
`ifdef CARD_DECK_SHUFFLE_EN
                IDLE: begin
                    if (bus.shuffle) idx <= 6'd51;
                end
                PICK: begin
                    if (cand_ok) jdx <= cand;
                end
                SWAP: begin
                    idx <= idx - 6'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Deck storage: ordered fill during INIT, pairwise exchange during SWAP.
    always_ff @(posedge clk) begin
        if (state == INIT && init_go) begin
            deck[idx] <= (rank > 4'd10) ? 4'd10 : rank;
        end
`ifdef CARD_DECK_SHUFFLE_EN
        else if (state == SWAP) begin
            deck[idx] <= deck[jdx];
            deck[jdx] <= deck[idx];
        end
`endif
    end

    // Registered read port; out-of-range or not-ready reads return 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            card_q <= 4'd0;
        end else if (ready_int && bus.addrCard <= 6'd51) begin
            card_q <= deck[bus.addrCard];
        end else begin
            card_q <= 4'd0;
        end
    end

    assign bus.card  = card_q;
    assign bus.ready = ready_int;

endmodule

// File: tb/tb_card_deck_module.sv
// Directed testbench for card_deck_module: reset/INIT timing, ordered reads,
// out-of-range reads, and either the shuffle path (CARD_DECK_SHUFFLE_EN) or
// the shuffle-ignored path (default build).
module tb_card_deck_module;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   rb [0:51];

    card_deck_module_if bus ();

    card_deck_module #(.LFSR_SEED(16'hACE1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ordered_val(input int k);
        int r;
        r = (k % 13) + 1;
        return (r > 10) ? 10 : r;
    endfunction

    // Release reset at a falling edge, then check ready over the INIT window.
    task automatic release_and_check_init(input string tag);
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 53; e++) begin
            @(posedge clk);
            #1;
            if (e == 53) begin
                chk({tag, "_ready_53"}, int'(bus.ready), 1);
            end else begin
                chk({tag, "_ready_low"}, int'(bus.ready), 0);
                chk({tag, "_card_zero"}, int'(bus.card), 0);
            end
        end
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        @(negedge clk);
        bus.addrCard = 6'(addr);
        @(posedge clk);
        #1;
        chk(tag, int'(bus.card), exp);
    endtask

    task automatic read_all();
        for (int k = 0; k < 52; k++) begin
            @(negedge clk);
            bus.addrCard = 6'(k);
            @(posedge clk);
            #1;
            rb[k] = int'(bus.card);
        end
    endtask

    task automatic chk_ordered(input string tag);
        int errs;
        errs = 0;
        read_all();
        for (int k = 0; k < 52; k++) begin
            if (rb[k] != ordered_val(k)) errs++;
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        int sum;
        int cnt [1:10];
        int diffs;
        int waited;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.addrCard = 6'd0;
        bus.shuffle  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_card", int'(bus.card), 0);
        chk("rst_ready", int'(bus.ready), 0);

        release_and_check_init("init1");

        read_chk("rd_0", 0, 1);
        read_chk("rd_9", 9, 10);
        read_chk("rd_12", 12, 10);
        read_chk("rd_13", 13, 1);
        read_chk("rd_51", 51, 10);
        read_chk("rd_52", 52, 0);
        read_chk("rd_63", 63, 0);
        read_chk("rd_1", 1, 2);

`ifdef CARD_DECK_SHUFFLE_EN
        @(negedge clk);
        bus.addrCard = 6'd0;
        bus.shuffle  = 1'b1;
        @(posedge clk);
        #1;
        chk("shuf_ready_drop", int'(bus.ready), 0);
        chk("shuf_preread", int'(bus.card), 1);
        @(negedge clk);
        bus.shuffle = 1'b0;
        @(posedge clk);
        #1;
        chk("shuf_card_zero", int'(bus.card), 0);

        waited = 0;
        while (!bus.ready && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("shuf_done", int'(bus.ready), 1);

        read_all();
        sum = 0;
        diffs = 0;
        for (int v = 1; v <= 10; v++) cnt[v] = 0;
        for (int k = 0; k < 52; k++) begin
            sum += rb[k];
            if (rb[k] >= 1 && rb[k] <= 10) cnt[rb[k]]++;
            if (rb[k] != ordered_val(k)) diffs++;
        end
        chk("shuf_sum", sum, 340);
        for (int v = 1; v <= 10; v++) begin
            chk($sformatf("shuf_count_%0d", v), cnt[v], (v == 10) ? 16 : 4);
        end
        chk("shuf_differs", int'(diffs > 0), 1);

        @(negedge clk);
        bus.shuffle = 1'b1;
        @(negedge clk);
        bus.shuffle = 1'b0;
        repeat (19) @(negedge clk);
        chk("midshuf_busy", int'(bus.ready), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midshuf_rst_ready", int'(bus.ready), 0);
        release_and_check_init("init2");
        chk_ordered("reinit_ordered");
`else
        @(negedge clk);
        bus.addrCard = 6'd13;
        bus.shuffle  = 1'b1;
        @(posedge clk);
        #1;
        chk("noshuf_ready", int'(bus.ready), 1);
        chk("noshuf_card", int'(bus.card), 1);
        @(negedge clk);
        bus.shuffle = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("noshuf_ready_hold", int'(bus.ready), 1);
        end
        chk_ordered("noshuf_ordered");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/card_deck_module.md
# card_deck_module

Card source for the blackjack game. It holds a 52-card deck of blackjack values and answers the state machine's `addrCard` requests with a registered `card` value one cycle later. On request it shuffles the deck in place with an LFSR-driven Fisher–Yates pass. It sits between the game state machine and nothing else: it is the responder for the card-fetch interface the game FSM initiates.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded at reset; must be nonzero.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `addrCard`  input  6  deck index requested by the game FSM; valid range 0–51.
- `shuffle`  input  1  one-cycle request to shuffle; sampled only when `ready`=1.
- `card`  output  4  registered card value 1–10 (Ace=1), or 0 when no valid card is available.
- `ready`  output  1  high when the deck is stable and `card` is meaningful.

## Operation
- Storage is `deck[0:51]`, 4 bits per entry. It holds values only; the game FSM resolves the Ace as 1 or 11.
- Ordered deck: entry k holds rank r = (k mod 13)+1 and value min(r,10). So k=0→1, k=9→10, k=10..12→10, k=13→1.
- Free-running 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1. It advances every cycle outside reset, including in IDLE, so request timing adds entropy.
- FSM states:
  - INIT: writes `deck[i]` with its ordered value, i=0..51, one entry per cycle. After i=51 it goes to IDLE with i=51.
  - IDLE: `ready`=1. If `shuffle`=1, it sets i=51 and goes to PICK. Otherwise it stays.
  - PICK:
    - Candidate j = LFSR[5:0] & m(i), where m(i) = (smallest power of two ≥ i+1) − 1.
    - If j ≤ i, it latches j and goes to SWAP. Otherwise it stays in PICK; the LFSR has advanced.
  - SWAP: exchanges `deck[i]` and `deck[j]` in one cycle (j=i is legal and leaves the deck unchanged), then decrements i. If the new i is 0 it goes to IDLE; otherwise it goes to PICK.
- Read path:
  - Every cycle, `card` <= `deck[addrCard]` if `ready`=1 and `addrCard` ≤ 51.
  - Otherwise `card` <= 0.
- A `shuffle` pulse outside IDLE is ignored. It is not queued.
- Out-of-range `addrCard` (52–63) gives `card`=0 and never wraps.

## Timing
- Reset values: `card`=0, `ready`=0, FSM=INIT, i=0, LFSR=`LFSR_SEED`.
- Reset asserted mid-shuffle aborts the pass. The deck is fully rewritten to ordered by INIT after release.
- INIT takes 52 cycles. `ready` rises on the 53rd rising edge after reset deassertion.
- Read latency is 1 cycle: the address presented before edge N appears on `card` after edge N. It is a fully pipelined read, so a new address can be issued every cycle.
- When `shuffle`=1 is sampled at an edge, `ready` drops after that same edge. `card` reads 0 from the following edge until `ready` returns.
- Shuffle duration is 51 SWAP cycles plus PICK cycles. Each PICK accepts with probability ≥ 1/2. The bench timeout is 2000 cycles.
- `ready` returns high on the edge that leaves the final SWAP. A read issued in that cycle returns shuffled data on the next edge.
- If `shuffle` and an address change occur together in IDLE, the read for that edge completes from the pre-shuffle deck.

## Configuration
- `CARD_DECK_SHUFFLE_EN` defined:
  - PICK/SWAP states and the LFSR are compiled in.
  - Behaviour is as described above.
- `CARD_DECK_SHUFFLE_EN` not defined:
  - The LFSR, PICK and SWAP are removed.
  - `shuffle` is ignored and the FSM stays in IDLE after INIT.
  - `ready` stays high after INIT.
  - The deck remains in ordered order.
  - `LFSR_SEED` is unused.

## Test plan
- Reset release, then poll `ready` → `ready`=0 for 52 edges and 1 at edge 53; `card`=0 throughout.
- After `ready`, drive `addrCard` 0, 9, 12, 13, 51 on successive cycles → `card` 1, 10, 10, 1, 10, each one cycle later.
- `addrCard`=52, then 63 → `card`=0, 0.
- Pulse `shuffle` → `ready` falls next edge and returns within 2000 cycles. Then read all 52 entries:
  - value sum is 340;
  - four 1s, four of each 2–9, sixteen 10s;
  - with the default seed, order differs from ordered.
- Assert `reset` low 20 cycles into a shuffle, then release → INIT reruns. After `ready`, the ordered readback matches the second test.
- Build without `CARD_DECK_SHUFFLE_EN` and pulse `shuffle` → `ready` stays 1 and the readback remains ordered.
